// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB responder with a word-addressed register array and
// programmable wait states. Optional macro APB_SLVERR_EN drives pslverr
// for bad addresses; without it pslverr stays 0 and bad accesses are
// silently dropped (writes) or return 0 (reads).
module apb_slave_mem #(
  parameter int unsigned SLAVE_IDX   = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WS = CW'(WAIT_STATES);
`ifdef APB_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [AW-1:0]   lat_idx, lat_idx_nx;
  logic            lat_wr, lat_wr_nx;
  logic            lat_bad, lat_bad_nx;
  logic [31:0]     lat_wdata, lat_wdata_nx;
  logic [31:0]     prdata_nx;
  logic            pready_nx, pslverr_nx;
  logic            mem_we_c;
  logic [31:0]     mem [DEPTH];

  logic            sel_c;
  logic [31:0]     offset_c;
  logic [AW-1:0]   idx_c;
  logic            bad_c;

  // Address decode of the live bus (only meaningful in the setup cycle)
  assign sel_c    = psel[SLAVE_IDX];
  assign offset_c = paddr - BASE_ADDR;
  assign idx_c    = offset_c[AW+1:2];
  assign bad_c    = (offset_c >= 32'(DEPTH * 4)) || (paddr[1:0] != 2'b00);

  // Next-state, latch and registered-response logic
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lat_idx_nx   = lat_idx;
    lat_wr_nx    = lat_wr;
    lat_bad_nx   = lat_bad;
    lat_wdata_nx = lat_wdata;
    prdata_nx    = prdata;
    pready_nx    = pready;
    pslverr_nx   = pslverr;
    mem_we_c     = 1'b0;

    case (state)
      IDLE: begin
        prdata_nx  = '0;
        pready_nx  = 1'b0;
        pslverr_nx = 1'b0;
        cnt_nx     = '0;
        // penable without a preceding setup is ignored here
        if (sel_c && !penable) begin
          lat_idx_nx   = idx_c;
          lat_wr_nx    = pwrite;
          lat_bad_nx   = bad_c;
          lat_wdata_nx = pwdata;
          state_nx     = ACCESS;
          if (WS == '0) begin
            pready_nx  = 1'b1;
            pslverr_nx = SLVERR_EN && bad_c;
            prdata_nx  = (!pwrite && !bad_c) ? mem[idx_c] : '0;
          end else begin
            cnt_nx = WS;
          end
        end
      end

      ACCESS: begin
        if (!sel_c) begin
          // Abort: drop the transfer without committing anything
          state_nx   = IDLE;
          cnt_nx     = '0;
          prdata_nx  = '0;
          pready_nx  = 1'b0;
          pslverr_nx = 1'b0;
        end else if (penable) begin
          if (pready) begin
            mem_we_c   = lat_wr && !lat_bad;
            state_nx   = IDLE;
            prdata_nx  = '0;
            pready_nx  = 1'b0;
            pslverr_nx = 1'b0;
          end else begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1)) begin
              pready_nx  = 1'b1;
              pslverr_nx = SLVERR_EN && lat_bad;
              prdata_nx  = (!lat_wr && !lat_bad) ? mem[lat_idx] : '0;
            end
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State, latched transfer and response registers
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wr    <= 1'b0;
      lat_bad   <= 1'b0;
      lat_wdata <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lat_idx   <= lat_idx_nx;
      lat_wr    <= lat_wr_nx;
      lat_bad   <= lat_bad_nx;
      lat_wdata <= lat_wdata_nx;
      prdata    <= prdata_nx;
      pready    <= pready_nx;
      pslverr   <= pslverr_nx;
    end
  end

  // Register array, cleared on reset, written at the completion edge
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (mem_we_c) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: two instances, one with no wait states (psel bit 0) and
// one with three wait states (psel bit 2), sharing the other bus signals.
module tb_apb_slave_mem;

`ifdef APB_SLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  psel0, psel3;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  apb_slave_mem #(.SLAVE_IDX(0), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_mem #(.SLAVE_IDX(2), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  function automatic logic [31:0] rd(input int tgt);
    return (tgt == 0) ? prdata0 : prdata3;
  endfunction

  function automatic logic rdy(input int tgt);
    return (tgt == 0) ? pready0 : pready3;
  endfunction

  function automatic logic er(input int tgt);
    return (tgt == 0) ? pslverr0 : pslverr3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // One full APB transfer; scrambles the bus during access to prove latching
  task automatic xfer(input int tgt, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int exp_wait,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int   waits;
    logic got;
    if (tgt == 0) psel0 = 3'b001; else psel3 = 3'b100;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    step();
    penable = 1'b1; pwrite = ~wr; paddr = ~addr; pwdata = ~wd;
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rdy(tgt)) got = 1'b1;
      else begin
        chk({tag, " prdata-before-ready"}, rd(tgt), 32'h0);
        waits++;
        step();
      end
    end
    chk({tag, " wait-cycles"}, 32'(waits), 32'(exp_wait));
    chk({tag, " prdata"}, rd(tgt), exp_rd);
    chk({tag, " pslverr"}, 32'(er(tgt)), 32'(exp_err));
    step();
    chk({tag, " pready-cleared"}, 32'(rdy(tgt)), 32'h0);
    psel0 = 3'b000; psel3 = 3'b000; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1;
    psel0 = 3'b000; psel3 = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    step(); step();
    chk("reset pready0",  32'(pready0),  32'h0);
    chk("reset prdata0",  prdata0,       32'h0);
    chk("reset pslverr0", 32'(pslverr0), 32'h0);
    chk("reset pready3",  32'(pready3),  32'h0);
    hreset = 1'b0;
    step();

    // Basic write then read, no wait states
    xfer(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, "ws0 wr 0x4");
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, "ws0 rd 0x4");

    // Three wait states on the second instance
    xfer(1, 1'b0, 32'h8000_0000, 32'h0, 3, 32'h0, 1'b0, "ws3 rd 0x0");

    // Wrong psel bit: no response, no write
    psel0 = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0008; pwdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      step();
      penable = 1'b1;
      chk("unselected pready", 32'(pready0), 32'h0);
    end
    psel0 = 3'b000; penable = 1'b0;
    step();
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, 0, 32'h0, 1'b0, "unselected readback");

    // penable without setup is ignored
    psel0 = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8000_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no-setup pready", 32'(pready0), 32'h0);
    end
    psel0 = 3'b000; penable = 1'b0;
    step();

    // Back-to-back writes, then back-to-back reads
    xfer(0, 1'b1, 32'h8000_0000, 32'h1, 0, 32'h0, 1'b0, "b2b wr0");
    xfer(0, 1'b1, 32'h8000_0004, 32'h2, 0, 32'h0, 1'b0, "b2b wr1");
    xfer(0, 1'b1, 32'h8000_0008, 32'h3, 0, 32'h0, 1'b0, "b2b wr2");
    xfer(0, 1'b1, 32'h8000_000C, 32'h4, 0, 32'h0, 1'b0, "b2b wr3");

    // Bad address accesses and the last valid word
    xfer(0, 1'b1, 32'h8000_0040, 32'h99, 0, 32'h0, ERR_EN, "bad wr 0x40");
    xfer(0, 1'b1, 32'h8000_003C, 32'hCAFE, 0, 32'h0, 1'b0, "wr last word");
    xfer(0, 1'b0, 32'h8000_003C, 32'h0, 0, 32'hCAFE, 1'b0, "rd last word");
    xfer(0, 1'b0, 32'h8000_0002, 32'h0, 0, 32'h0, ERR_EN, "bad rd unaligned");
    xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 0, 32'h0, ERR_EN, "bad rd below base");

    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 0, 32'h1, 1'b0, "b2b rd0");
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 0, 32'h2, 1'b0, "b2b rd1");
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, 0, 32'h3, 1'b0, "b2b rd2");
    xfer(0, 1'b0, 32'h8000_000C, 32'h0, 0, 32'h4, 1'b0, "b2b rd3");

    // Write immediately followed by read of the same word, wait states on
    xfer(1, 1'b1, 32'h8000_0008, 32'h42, 3, 32'h0, 1'b0, "ws3 wr 0x8");
    xfer(1, 1'b0, 32'h8000_0008, 32'h0, 3, 32'h42, 1'b0, "ws3 rd 0x8");

    // Abort: psel drops during access, nothing written
    psel3 = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0000; pwdata = 32'h77;
    step();
    penable = 1'b1;
    step();
    psel3 = 3'b000; penable = 1'b0;
    step();
    chk("abort pready", 32'(pready3), 32'h0);
    xfer(1, 1'b0, 32'h8000_0000, 32'h0, 3, 32'h0, 1'b0, "abort readback");

    // Reset in the 2nd access cycle of a wait-state write
    xfer(1, 1'b1, 32'h8000_0004, 32'hABCD, 3, 32'h0, 1'b0, "ws3 wr 0x4");
    psel3 = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0000; pwdata = 32'h1234;
    step();
    penable = 1'b1;
    step();
    hreset = 1'b1;
    #1;
    chk("midreset pready3", 32'(pready3), 32'h0);
    chk("midreset prdata3", prdata3, 32'h0);
    psel3 = 3'b000; penable = 1'b0;
    step();
    hreset = 1'b0;
    step();
    xfer(1, 1'b0, 32'h8000_0000, 32'h0, 3, 32'h0, 1'b0, "midreset rd 0x0");
    xfer(1, 1'b0, 32'h8000_0004, 32'h0, 3, 32'h0, 1'b0, "midreset rd 0x4");
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 0, 32'h0, 1'b0, "midreset ws0 rd 0x4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB responder at the far end of the AHB-to-APB bridge.
- Decodes one bit of the bridge's 3-bit one-hot psel and executes APB setup/access transfers against an internal word-addressed register array.
- Inserts a programmable number of wait states through pready.
- Returns read data on prdata and optionally flags bad addresses on pslverr.
- Replaces the pass-through APB interface as the bus-functional endpoint, so bridge read and write paths can be checked end to end.

Parameters:
- SLAVE_IDX, 0: which psel bit selects this slave (0..2).
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- DEPTH, 16: number of 32-bit words (power of 2, 2..256).
- WAIT_STATES, 0: access cycles inserted before pready (0..15).

Ports:
- hclk  in  1  system clock; all state updates on the rising edge.
- hreset  in  1  reset; asynchronous, active-high.
- psel  in  3  one-hot slave select from the bridge.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid while pready=1 on a read.
- pready  out  1  transfer-complete strobe, registered.
- pslverr  out  1  error response, valid with pready.

Behaviour:
- sel = psel[SLAVE_IDX]. offset = paddr - BASE_ADDR. Word index = offset[log2(DEPTH)+1:2].
- Address is bad if offset >= DEPTH*4 or paddr[1:0] != 0.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; wait counter = 0.
  - prdata = 0, pready = 0, pslverr = 0.
  - Every array word = 0.
  - A transfer in progress is abandoned with no write.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On sel=1 and penable=0 (setup): latch paddr, pwrite, pwdata and the bad flag; go to ACCESS.
  - If WAIT_STATES=0: at that same edge set pready=1, and for a read load prdata = array[idx] (0 if bad).
  - Otherwise load counter = WAIT_STATES and keep pready=0.
  - penable=1 without a prior setup is ignored and produces no response.
- ACCESS, pready=0:
  - Each edge with sel=1 and penable=1 decrements the counter.
  - When the counter goes 1 -> 0, set pready=1 and load prdata as in IDLE.
- Timing result: pready is high in access cycle WAIT_STATES+1 after setup. Minimum transfer length is 2 cycles.
- ACCESS, pready=1, sel=1, penable=1 (completion edge):
  - Writes commit array[idx] = latched pwdata, unless the address is bad.
  - Clear pready and pslverr, set prdata = 0, return to IDLE.
- Back-to-back transfers: a new setup in the cycle after completion is accepted from IDLE with no dead cycle.
- sel drops during ACCESS (abort): return to IDLE next edge, no write, pready/prdata/pslverr cleared.
- Latched address, control and data are used for the whole transfer. Changes on paddr, pwrite or pwdata during ACCESS are ignored.
- prdata is 0 whenever pready=0, and on write completions.
- The array is read-first. A read issued immediately after a write to the same word returns the new value, because the write commits before the next setup.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined: pslverr is asserted together with pready for any bad address. The write is suppressed and read data is 0.
- Undefined: pslverr is tied 0. Bad-address writes are silently dropped and reads return 0.
- Latency and handshake timing are identical in both builds.

Test Plan:
- Reset then write/read, WAIT_STATES=0, psel=3'b001:
  - Write 0x8000_0004 <= 0xDEAD_BEEF: pready high in the first access cycle.
  - Then read 0x8000_0004: prdata=0xDEAD_BEEF with pready, pslverr=0.
- WAIT_STATES=3: read of 0x8000_0000 holds pready=0 for 3 access cycles and is high in the 4th; prdata=0 before that.
- Back-to-back writes, 4 incrementing addresses 0x8000_0000..0x8000_000C with data 1..4, no idle cycles:
  - All four complete.
  - Readback returns 1, 2, 3, 4.
- Slave not selected: psel=3'b010 with SLAVE_IDX=0 writing 0x8000_0008 <= 0x55 gives pready=0 throughout; later readback of 0x8000_0008 = 0.
- With APB_SLVERR_EN:
  - Write 0x8000_0040 (DEPTH=16): pslverr=1 with pready, no word modified.
  - Read 0x8000_0002: pslverr=1, prdata=0.
- Reset mid-transfer, WAIT_STATES=3:
  - hreset asserted during the 2nd access cycle of a write to 0x8000_0000 <= 0x1234.
  - pready=0 immediately; readback of 0x8000_0000 after reset = 0.
